// File: rtl/pipe_sprite_controller.sv
// pipe_sprite_controller
//   Owns one scrolling pipe pair. It tracks the pipe's horizontal position,
//   draws a random gap height on every respawn, and pulses score_pulse when
//   the pipe passes the bird. For each VGA pixel it forms an address into the
//   50x100 pipe sprite ROM. It then registers the returned palette index for
//   the colour mapper.
//
//   State table:
//     IDLE    | pipe parked at START_X, waiting for run
//     RUN     | pipe scrolls SPEED pixels on each frame_start
//     PAUSE   | run dropped, position frozen
//     RESPAWN | one cycle: pipe back to START_X, new gap_top from lfsr
//
// Ports:
//   Clk            in   pixel clock
//   Reset          in   synchronous, active-high
//   frame_start    in   one-cycle pulse at the start of vertical blank
//   run            in   game active; low pauses scrolling
//   DrawX, DrawY   in   current pixel column / row (10 bits each)
//   rom_data       in   palette index from the sprite ROM (combinational on rom_addr)
//   rom_addr       out  sprite ROM address; reflects the pixel from 1 cycle earlier
//   pipe_on        out  opaque pipe pixel; reflects the pixel from 2 cycles earlier
//   pipe_color_idx out  palette index for that pixel
//   pipe_x         out  signed left edge of the pipe
//   gap_top        out  first row of the opening
//   score_pulse    out  one-cycle pulse when the pipe passes BIRD_X
module pipe_sprite_controller #(
  parameter int SPRITE_W = 50,
  parameter int SPRITE_H = 100,
  parameter int SCREEN_H = 480,
  parameter int START_X  = 640,
  parameter int SPEED    = 2,
  parameter int GAP      = 120,
  parameter int GAP_BASE = 60,
  parameter int BIRD_X   = 160
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               frame_start,
  input  logic               run,
  input  logic [9:0]         DrawX,
  input  logic [9:0]         DrawY,
  input  logic [2:0]         rom_data,
  output logic [12:0]        rom_addr,
  output logic               pipe_on,
  output logic [2:0]         pipe_color_idx,
  output logic signed [10:0] pipe_x,
  output logic [9:0]         gap_top,
  output logic               score_pulse
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, RESPAWN} state_t;

  localparam logic signed [10:0] START_X_S = 11'(START_X);
  localparam logic signed [10:0] SPEED_S   = 11'(SPEED);
  localparam logic signed [10:0] NEG_W_S   = 11'(-SPRITE_W);
  localparam logic signed [11:0] W_S12     = 12'(SPRITE_W);
  localparam logic signed [11:0] SPEED_S12 = 12'(SPEED);
  localparam logic signed [11:0] BIRD_S12  = 12'(BIRD_X);
  localparam logic [9:0]         GAP_TOP_RST = 10'd180;

  state_t state, state_next;
  logic signed [10:0] pipe_x_next, moved_x;
  logic signed [11:0] old_edge, new_edge;
  logic [9:0]  gap_next;
  logic        score_next;
  logic [7:0]  lfsr;
  logic        lfsr_fb;

  // Fibonacci LFSR, taps 8,6,5,4; it free-runs so the gap depends on the
  // cycle at which the respawn happens.
  assign lfsr_fb = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];

  assign moved_x  = pipe_x - SPEED_S;
  assign old_edge = $signed({pipe_x[10], pipe_x}) + W_S12;
  assign new_edge = old_edge - SPEED_S12;

  always_comb begin
    state_next  = state;
    pipe_x_next = pipe_x;
    gap_next    = gap_top;
    score_next  = 1'b0;
    case (state)
      IDLE: begin
        pipe_x_next = START_X_S;
        if (run) state_next = RUN;
      end
      RUN: begin
        if (!run) begin
          state_next = PAUSE;
        end else if (frame_start) begin
          pipe_x_next = moved_x;
          if (moved_x <= NEG_W_S) state_next = RESPAWN;
          // Right edge crossing the bird column happens on exactly one move.
          if ((old_edge > BIRD_S12) && (new_edge <= BIRD_S12)) score_next = 1'b1;
        end
      end
      PAUSE: begin
        if (run) state_next = RUN;
      end
      RESPAWN: begin
        pipe_x_next = START_X_S;
        gap_next    = 10'(GAP_BASE) + {2'b00, lfsr};
        state_next  = RUN;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= IDLE;
      pipe_x      <= START_X_S;
      gap_top     <= GAP_TOP_RST;
      lfsr        <= 8'hA5;
      score_pulse <= 1'b0;
    end else begin
      state       <= state_next;
      pipe_x      <= pipe_x_next;
      gap_top     <= gap_next;
      lfsr        <= {lfsr[6:0], lfsr_fb};
      score_pulse <= score_next;
    end
  end

  // Address stage
  logic signed [11:0] col;
  logic               hit_x, in_upper, in_lower, hit, hit1;
  logic [10:0]        gap_bot;
  logic [10:0]        row_raw;
  logic [6:0]         row;
  logic [12:0]        addr_calc;

  assign col      = $signed({2'b00, DrawX}) - $signed({pipe_x[10], pipe_x});
  assign hit_x    = (col >= 12'sd0) && (col < W_S12);
  assign gap_bot  = {1'b0, gap_top} + 11'(GAP);
  assign in_upper = DrawY < gap_top;
  // Rows below the visible area never draw, even though the pipe body
  // would otherwise continue into vertical blank.
  assign in_lower = ({1'b0, DrawY} >= gap_bot) && ({1'b0, DrawY} < 11'(SCREEN_H));

  always_comb begin
    row_raw = 11'd0;
    if (in_upper)      row_raw = {1'b0, gap_top - 10'd1 - DrawY};
    else if (in_lower) row_raw = {1'b0, DrawY} - gap_bot;
  end

  // Long pipe bodies repeat the last sprite row.
  assign row       = (row_raw >= 11'(SPRITE_H)) ? 7'(SPRITE_H - 1) : row_raw[6:0];
  assign hit       = hit_x && (in_upper || in_lower);
  assign addr_calc = ({6'b0, row} * 13'(SPRITE_W)) + {col[11], col};

  always_ff @(posedge Clk) begin
    if (Reset) begin
      rom_addr       <= 13'd0;
      hit1           <= 1'b0;
      pipe_on        <= 1'b0;
      pipe_color_idx <= 3'd0;
    end else begin
      rom_addr       <= hit ? addr_calc : 13'd0;
      hit1           <= hit;
      // Palette index 0 is transparent.
      pipe_color_idx <= hit1 ? rom_data : 3'd0;
      pipe_on        <= hit1 && (rom_data != 3'd0);
    end
  end

endmodule

// File: tb/tb_pipe_sprite_controller.sv
module tb_pipe_sprite_controller;

  logic               Clk = 1'b0;
  logic               Reset, frame_start, run;
  logic [9:0]         DrawX, DrawY;
  logic [2:0]         rom_data;
  logic [12:0]        rom_addr;
  logic               pipe_on;
  logic [2:0]         pipe_color_idx;
  logic signed [10:0] pipe_x;
  logic [9:0]         gap_top;
  logic               score_pulse;

  logic [1:0] rom_mode;
  logic [7:0] m_lfsr;
  int errors = 0;
  int checks = 0;
  int score_cnt = 0;
  logic signed [10:0] exp_x;
  logic [9:0]         exp_gap;

  pipe_sprite_controller dut (
    .Clk(Clk), .Reset(Reset), .frame_start(frame_start), .run(run),
    .DrawX(DrawX), .DrawY(DrawY), .rom_data(rom_data), .rom_addr(rom_addr),
    .pipe_on(pipe_on), .pipe_color_idx(pipe_color_idx), .pipe_x(pipe_x),
    .gap_top(gap_top), .score_pulse(score_pulse)
  );

  always #5 Clk = ~Clk;

  // Behavioural sprite ROM: all-transparent, constant 3, or low address bits.
  assign rom_data = (rom_mode == 2'd0) ? 3'd0 :
                    (rom_mode == 2'd1) ? 3'd3 : rom_addr[2:0];

  // Reference LFSR (taps 8,6,5,4) used to predict the respawn gap.
  always @(posedge Clk) begin
    if (Reset) m_lfsr <= 8'hA5;
    else       m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end

  always @(negedge Clk) if (score_pulse) score_cnt++;

  task automatic tick();
    @(posedge Clk); #1;
  endtask

  task automatic frame();
    frame_start = 1'b1; tick();
    frame_start = 1'b0; tick();
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame();
  endtask

  task automatic test_reset();
    Reset = 1'b1; run = 1'b0; frame_start = 1'b0; DrawX = 10'd0; DrawY = 10'd0; rom_mode = 2'd1;
    tick(); tick();
    Reset = 1'b0;
    checks++; if (rom_addr !== 13'd0) begin errors++; $display("FAIL reset_rom_addr: got %0d expected 0", rom_addr); end
    checks++; if (pipe_on !== 1'b0) begin errors++; $display("FAIL reset_pipe_on: got %0b expected 0", pipe_on); end
    checks++; if (pipe_color_idx !== 3'd0) begin errors++; $display("FAIL reset_idx: got %0d expected 0", pipe_color_idx); end
    checks++; if (pipe_x !== 11'sd640) begin errors++; $display("FAIL reset_pipe_x: got %0d expected 640", pipe_x); end
    checks++; if (gap_top !== 10'd180) begin errors++; $display("FAIL reset_gap_top: got %0d expected 180", gap_top); end
    checks++; if (score_pulse !== 1'b0) begin errors++; $display("FAIL reset_score: got %0b expected 0", score_pulse); end
    frames(2);
    checks++; if (pipe_x !== 11'sd640) begin errors++; $display("FAIL idle_hold: got %0d expected 640", pipe_x); end
  endtask

  task automatic test_scroll();
    run = 1'b1; tick();
    frames(10);
    checks++; if (pipe_x !== 11'sd620) begin errors++; $display("FAIL scroll10_x: got %0d expected 620", pipe_x); end
    checks++; if (gap_top !== 10'd180) begin errors++; $display("FAIL scroll10_gap: got %0d expected 180", gap_top); end
  endtask

  task automatic test_score();
    score_cnt = 0;
    frames(254);
    checks++; if (pipe_x !== 11'sd112) begin errors++; $display("FAIL pre_score_x: got %0d expected 112", pipe_x); end
    checks++; if (score_cnt !== 0) begin errors++; $display("FAIL pre_score_cnt: got %0d expected 0", score_cnt); end
    frame_start = 1'b1; tick();
    checks++; if (score_pulse !== 1'b1) begin errors++; $display("FAIL score_pulse_hi: got %0b expected 1", score_pulse); end
    frame_start = 1'b0; tick();
    checks++; if (score_pulse !== 1'b0) begin errors++; $display("FAIL score_pulse_lo: got %0b expected 0", score_pulse); end
    frames(5);
    checks++; if (pipe_x !== 11'sd100) begin errors++; $display("FAIL post_score_x: got %0d expected 100", pipe_x); end
    checks++; if (score_cnt !== 1) begin errors++; $display("FAIL score_once: got %0d expected 1", score_cnt); end
  endtask

  task automatic test_address();
    rom_mode = 2'd1;
    DrawX = 10'd110; DrawY = 10'd179; tick();
    checks++; if (rom_addr !== 13'd10) begin errors++; $display("FAIL addr_upper_row0: got %0d expected 10", rom_addr); end
    DrawY = 10'd0; tick();
    checks++; if (pipe_on !== 1'b1 || pipe_color_idx !== 3'd3) begin errors++; $display("FAIL out_upper_row0: got on=%0b idx=%0d expected on=1 idx=3", pipe_on, pipe_color_idx); end
    checks++; if (rom_addr !== 13'd4960) begin errors++; $display("FAIL addr_clamp_top: got %0d expected 4960", rom_addr); end
    DrawX = 10'd149; DrawY = 10'd479; tick();
    checks++; if (rom_addr !== 13'd4999) begin errors++; $display("FAIL addr_clamp_bottom: got %0d expected 4999", rom_addr); end
    DrawX = 10'd150; DrawY = 10'd0; tick();
    checks++; if (rom_addr !== 13'd0) begin errors++; $display("FAIL addr_col50: got %0d expected 0", rom_addr); end
    DrawX = 10'd99; tick();
    checks++; if (pipe_on !== 1'b0 || pipe_color_idx !== 3'd0) begin errors++; $display("FAIL out_col50: got on=%0b idx=%0d expected 0 0", pipe_on, pipe_color_idx); end
    checks++; if (rom_addr !== 13'd0) begin errors++; $display("FAIL addr_col_neg: got %0d expected 0", rom_addr); end
    DrawX = 10'd110; DrawY = 10'd250; tick();
    checks++; if (rom_addr !== 13'd0) begin errors++; $display("FAIL addr_gap_mid: got %0d expected 0", rom_addr); end
    DrawY = 10'd180; tick();
    checks++; if (pipe_on !== 1'b0) begin errors++; $display("FAIL out_gap_mid: got %0b expected 0", pipe_on); end
    checks++; if (rom_addr !== 13'd0) begin errors++; $display("FAIL addr_gap_first: got %0d expected 0", rom_addr); end
    DrawY = 10'd299; tick();
    checks++; if (rom_addr !== 13'd0) begin errors++; $display("FAIL addr_gap_last: got %0d expected 0", rom_addr); end
    rom_mode = 2'd0; DrawX = 10'd100; DrawY = 10'd300; tick();
    checks++; if (rom_addr !== 13'd0) begin errors++; $display("FAIL addr_lower_row0: got %0d expected 0", rom_addr); end
    tick();
    checks++; if (pipe_on !== 1'b0 || pipe_color_idx !== 3'd0) begin errors++; $display("FAIL out_transparent: got on=%0b idx=%0d expected 0 0", pipe_on, pipe_color_idx); end
    rom_mode = 2'd1; tick();
    checks++; if (pipe_on !== 1'b1 || pipe_color_idx !== 3'd3) begin errors++; $display("FAIL out_lower_opaque: got on=%0b idx=%0d expected 1 3", pipe_on, pipe_color_idx); end
    // Back-to-back pixels through the two-stage pipeline.
    rom_mode = 2'd2; DrawX = 10'd113; DrawY = 10'd178; tick();
    checks++; if (rom_addr !== 13'd63) begin errors++; $display("FAIL b2b_addr: got %0d expected 63", rom_addr); end
    DrawX = 10'd150; DrawY = 10'd0; tick();
    checks++; if (pipe_color_idx !== 3'd7 || pipe_on !== 1'b1) begin errors++; $display("FAIL b2b_idx1: got on=%0b idx=%0d expected 1 7", pipe_on, pipe_color_idx); end
    tick();
    checks++; if (pipe_color_idx !== 3'd0 || pipe_on !== 1'b0) begin errors++; $display("FAIL b2b_idx2: got on=%0b idx=%0d expected 0 0", pipe_on, pipe_color_idx); end
    rom_mode = 2'd1;
  endtask

  task automatic test_pause();
    run = 1'b0; frame_start = 1'b1; tick();
    frame_start = 1'b0; tick();
    frames(4);
    checks++; if (pipe_x !== 11'sd100) begin errors++; $display("FAIL pause_hold: got %0d expected 100", pipe_x); end
    run = 1'b1; tick(); tick();
    checks++; if (pipe_x !== 11'sd100) begin errors++; $display("FAIL resume_wait: got %0d expected 100", pipe_x); end
    frame();
    checks++; if (pipe_x !== 11'sd98) begin errors++; $display("FAIL resume_move: got %0d expected 98", pipe_x); end
  endtask

  task automatic test_respawn();
    frames(73);
    checks++; if (pipe_x !== -11'sd48) begin errors++; $display("FAIL pre_respawn_x: got %0d expected -48", pipe_x); end
    frame_start = 1'b1; tick();
    frame_start = 1'b0;
    checks++; if (pipe_x !== -11'sd50) begin errors++; $display("FAIL respawn_edge_x: got %0d expected -50", pipe_x); end
    exp_gap = 10'd60 + {2'b00, m_lfsr};
    tick();
    checks++; if (pipe_x !== 11'sd640) begin errors++; $display("FAIL respawn_x: got %0d expected 640", pipe_x); end
    checks++; if (gap_top !== exp_gap) begin errors++; $display("FAIL respawn_gap: got %0d expected %0d", gap_top, exp_gap); end
    frame();
    checks++; if (pipe_x !== 11'sd638) begin errors++; $display("FAIL after_respawn_x: got %0d expected 638", pipe_x); end
    checks++; if (score_cnt !== 1) begin errors++; $display("FAIL respawn_no_score: got %0d expected 1", score_cnt); end
  endtask

  task automatic test_reset_midline();
    frames(269);
    exp_x = 11'sd100;
    checks++; if (pipe_x !== exp_x) begin errors++; $display("FAIL midline_setup_x: got %0d expected %0d", pipe_x, exp_x); end
    rom_mode = 2'd1; DrawX = 10'd110; DrawY = 10'd0; tick(); tick();
    checks++; if (pipe_on !== 1'b1) begin errors++; $display("FAIL midline_setup_on: got %0b expected 1", pipe_on); end
    Reset = 1'b1; tick();
    checks++; if (rom_addr !== 13'd0 || pipe_on !== 1'b0 || pipe_color_idx !== 3'd0) begin errors++; $display("FAIL midline_reset_out: got addr=%0d on=%0b idx=%0d expected 0 0 0", rom_addr, pipe_on, pipe_color_idx); end
    checks++; if (pipe_x !== 11'sd640 || gap_top !== 10'd180) begin errors++; $display("FAIL midline_reset_pos: got x=%0d gap=%0d expected 640 180", pipe_x, gap_top); end
    Reset = 1'b0;
  endtask

  task automatic test_reset_respawn();
    run = 1'b1; tick();
    frames(344);
    frame_start = 1'b1; tick();
    frame_start = 1'b0;
    checks++; if (pipe_x !== -11'sd50) begin errors++; $display("FAIL rr_edge_x: got %0d expected -50", pipe_x); end
    Reset = 1'b1; tick();
    Reset = 1'b0; run = 1'b0;
    checks++; if (pipe_x !== 11'sd640 || gap_top !== 10'd180) begin errors++; $display("FAIL rr_pos: got x=%0d gap=%0d expected 640 180", pipe_x, gap_top); end
    checks++; if (rom_addr !== 13'd0 || pipe_on !== 1'b0 || score_pulse !== 1'b0) begin errors++; $display("FAIL rr_out: got addr=%0d on=%0b score=%0b expected 0 0 0", rom_addr, pipe_on, score_pulse); end
    DrawX = 10'd639; DrawY = 10'd0; tick(); tick();
    checks++; if (rom_addr !== 13'd0 || pipe_on !== 1'b0) begin errors++; $display("FAIL offscreen: got addr=%0d on=%0b expected 0 0", rom_addr, pipe_on); end
    frame();
    checks++; if (pipe_x !== 11'sd640) begin errors++; $display("FAIL rr_idle_x: got %0d expected 640", pipe_x); end
  endtask

  initial begin
    test_reset();
    test_scroll();
    test_score();
    test_address();
    test_pause();
    test_respawn();
    test_reset_midline();
    test_reset_respawn();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
